// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one 16-bit SRAM driver between an ifetch port (0) and a load/store port (1)
// Ports:
//   sck, rst            clock, asynchronous active-high reset
//   req[1:0]            per-port request (0=ifetch, 1=data)
//   rw0/rw1             access type per port, 1=write
//   addr0/1, wdata0/1   per-port byte address and write data
//   ack[1:0], rdata     one-cycle completion pulse and reassembled read data
//   busy                high whenever not idle
//   cs_n, mosi, miso    driver interface; mosi={rw, data16, word18, half}
module sram_arbiter #(
    parameter logic [11:0] REGION      = 12'h001,
    parameter bit          ROUND_ROBIN = 1'b1
) (
    input  logic        sck,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic        rw0,
    input  logic        rw1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    input  logic [15:0] miso,
    output logic [1:0]  ack,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        cs_n,
    output logic [35:0] mosi
);
    typedef enum logic [2:0] {IDLE, LO, HI, FIN, ERR} state_t;
    state_t      state, state_nx;
    logic        gnt, last_grant, rw_q, win;
    logic [17:0] word_q;
    logic [31:0] wdata_q, win_addr;
    logic [15:0] lo_q;
    logic        unused_ok;
    assign unused_ok = ^{addr0[1:0], addr1[1:0]};
    // Ties go to the port not served last; fixed mode always favours data.
    always_comb begin
        win      = req == 2'b01 ? 1'b0 : req == 2'b10 ? 1'b1 : ROUND_ROBIN ? ~last_grant : 1'b1;
        win_addr = win ? addr1 : addr0;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = |req ? (win_addr[31:20] == REGION ? LO : ERR) : IDLE;
            LO:      state_nx = HI;
            HI:      state_nx = FIN;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge sck or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            gnt        <= 1'b0;
            last_grant <= 1'b0;
            rw_q       <= 1'b0;
            word_q     <= '0;
            wdata_q    <= '0;
            lo_q       <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && |req) begin
                gnt        <= win;
                last_grant <= win;
                rw_q       <= win ? rw1 : rw0;
                word_q     <= win_addr[19:2];
                wdata_q    <= win ? wdata1 : wdata0;
            end
            // miso during HI carries the low half issued in LO.
            if (state == HI)
                lo_q <= miso;
        end
    end
    // Outputs decode only from registered state; miso feeds the high half directly in FIN.
    always_comb begin
        cs_n  = !(state == LO || state == HI);
        mosi  = state == LO ? {rw_q, wdata_q[15:0], word_q, 1'b0} :
                state == HI ? {rw_q, wdata_q[31:16], word_q, 1'b1} : 36'h0;
        ack   = (state == FIN || state == ERR) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
        rdata = (state == FIN && !rw_q) ? {miso, lo_q} : 32'h0;
        busy  = state != IDLE;
    end
endmodule
